mb_rtu_rx_framer: RTL

Parametrised Modbus RTU receive framer that sits between the UART bridge byte stream and the Modbus controller. It delimits frames by inter-character silence (t1.5 / t3.5), checks CRC-16 on the fly, filters on slave address and buffers up to NBUF complete frames for the controller. This lets the controller parse one frame while the next is still arriving.

---
 rtl/mb_pkg.sv | 16 +
 rtl/mb_crc16.sv | 16 +
 rtl/mb_rtu_rx_framer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mb_pkg.sv
// mb_pkg: shared constants, status bit positions and receive FSM states for the Modbus RTU path
package mb_pkg;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam int STAT_CRC_OK = 0;
  localparam int STAT_T15 = 1;
  localparam int STAT_RX_ERR = 2;
  localparam int STAT_TRUNC = 3;
  typedef enum logic [2:0] {
    WAIT35 = 3'd0,
    IDLE   = 3'd1,
    RECV   = 3'd2,
    GAP    = 3'd3,
    COMMIT = 3'd4
  } state_t;
endpackage

// File: rtl/mb_crc16.sv
// mb_crc16: combinational Modbus CRC-16 byte update
//   crc_in  : running CRC
//   data    : byte to fold in
//   crc_out : CRC after the byte (8 unrolled reflected shift steps)
module mb_crc16
  import mb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC_POLY : crc_out >> 1;
  end
endmodule

// File: rtl/mb_rtu_rx_framer.sv
// mb_rtu_rx_framer: Modbus RTU receive framer with silence delimiting, CRC check, address filter and frame ring
//   PCLK/PRESETn          : clock, async active-low reset
//   char_clks, en         : character time in clocks, framer enable
//   rx_data/valid/err     : byte stream from the UART bridge
//   self_addr, addr_filt  : slave address filter
//   frm_valid/len/stat    : head frame of the ring
//   rd_addr -> rd_data    : registered byte read of the head frame
//   frm_pop               : release head frame
//   crc_err_p/runt_p/ovr_p: one-cycle event pulses in the commit cycle
module mb_rtu_rx_framer
  import mb_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int NBUF = 2,
  parameter int CW = 20,
  localparam int LW = $clog2(MAX_LEN) + 1
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic [CW-1:0] char_clks,
  input  logic          en,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_err,
  input  logic [7:0]    self_addr,
  input  logic          addr_filt,
  output logic          frm_valid,
  output logic [LW-1:0] frm_len,
  output logic [3:0]    frm_stat,
  input  logic [LW-2:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frm_pop,
  output logic          crc_err_p,
  output logic          runt_p,
  output logic          ovr_p
);
  localparam int AW = LW - 1;
  localparam int IW = NBUF > 1 ? $clog2(NBUF) : 1;
  localparam int NW = $clog2(NBUF + 1);
  state_t st, st_nx;
  logic [CW-1:0] cnt;
  logic [CW+1:0] sil, t15, t35;
  logic [LW-1:0] len;
  logic [15:0] crc, crc_base, crc_nx;
  logic [7:0] a0;
  logic trunc, rxe, t15e, drop;
  logic [IW-1:0] wr_idx, rd_idx, wr_nx, wr_inc, rd_inc;
  logic [NW-1:0] count, count_nx;
  logic [7:0] mem [NBUF][MAX_LEN];
  logic [LW-1:0] len_q [NBUF];
  logic [3:0] stat_q [NBUF];
  logic open, more, crc_ok, keep, in_commit, commit, pop, drop_open, has_room, store;
  assign sil = {2'b00, cnt};
  assign t15 = {2'b00, char_clks} + {3'b000, char_clks[CW-1:1]};
  assign t35 = {1'b0, char_clks, 1'b0} + {2'b00, char_clks} + {3'b000, char_clks[CW-1:1]};
  // A byte in COMMIT starts the next frame, exactly like a byte in IDLE.
  assign open = en & rx_valid & (st == IDLE || st == COMMIT);
  assign more = en & rx_valid & (st == RECV || st == GAP);
  assign crc_ok = (crc == 16'h0000) & ~trunc;
  assign keep = ~addr_filt | (a0 == self_addr) | (a0 == 8'h00);
  assign in_commit = en & (st == COMMIT);
  assign commit = in_commit & ~drop & (len >= LW'(4)) & keep;
  assign pop = frm_pop & frm_valid;
  assign wr_inc = (wr_idx == IW'(NBUF - 1)) ? '0 : wr_idx + 1'b1;
  assign rd_inc = (rd_idx == IW'(NBUF - 1)) ? '0 : rd_idx + 1'b1;
  assign wr_nx = commit ? wr_inc : wr_idx;
  assign count_nx = count + NW'(commit) - NW'(pop);
  // Free-slot test uses the post-commit/pop occupancy so a frame opening in COMMIT never lands on a live buffer.
  assign drop_open = count_nx == NW'(NBUF);
  assign has_room = len < LW'(MAX_LEN);
  assign store = (open & ~drop_open) | (more & ~drop & has_room);
  assign crc_base = open ? CRC_INIT : crc;
  assign frm_valid = count != '0;
  assign frm_len = len_q[rd_idx];
  assign frm_stat = stat_q[rd_idx];
  assign ovr_p = in_commit & drop;
  assign runt_p = in_commit & ~drop & (len < LW'(4));
  assign crc_err_p = in_commit & ~crc_ok;
  mb_crc16 u_crc (.crc_in(crc_base), .data(rx_data), .crc_out(crc_nx));
  always_comb begin
    st_nx = !en ? WAIT35 :
            st == WAIT35 ? ((!rx_valid && sil >= t35) ? IDLE : WAIT35) :
            st == IDLE ? (rx_valid ? RECV : IDLE) :
            st == RECV ? ((!rx_valid && sil >= t15) ? GAP : RECV) :
            st == GAP ? (rx_valid ? RECV : (sil >= t35 ? COMMIT : GAP)) :
            (rx_valid ? RECV : IDLE);
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      st <= WAIT35;
      cnt <= '0;
      len <= '0;
      crc <= CRC_INIT;
      a0 <= '0;
      trunc <= 1'b0;
      rxe <= 1'b0;
      t15e <= 1'b0;
      drop <= 1'b0;
      wr_idx <= '0;
      rd_idx <= '0;
      count <= '0;
      rd_data <= '0;
      for (int i = 0; i < NBUF; i++) begin
        len_q[i] <= '0;
        stat_q[i] <= '0;
      end
    end else begin
      st <= st_nx;
      cnt <= rx_valid ? '0 : (&cnt ? cnt : cnt + 1'b1);
      if (open) begin
        len <= LW'(1);
        crc <= crc_nx;
        a0 <= rx_data;
        trunc <= 1'b0;
        rxe <= rx_err;
        t15e <= 1'b0;
        drop <= drop_open;
      end else if (more) begin
        if (has_room) begin
          len <= len + 1'b1;
          crc <= crc_nx;
        end else trunc <= 1'b1;
        rxe <= rxe | rx_err;
        t15e <= t15e | (st == GAP);
      end
      if (commit) begin
        len_q[wr_idx] <= len;
        stat_q[wr_idx] <= {trunc, rxe, t15e, crc_ok};
      end
      wr_idx <= wr_nx;
      rd_idx <= pop ? rd_inc : rd_idx;
      count <= count_nx;
      rd_data <= mem[rd_idx][rd_addr];
    end
  end
  always_ff @(posedge PCLK) begin
    if (store) mem[wr_nx][open ? '0 : len[AW-1:0]] <= rx_data;
  end
endmodule
